// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial subtractor. It recovers one adder operand from the
//             17-bit sum and the other operand: diff = sum_in - n2.
//             The difference is computed one bit per clock, LSB first.
//             Valid/ready handshake on the operand side and the result side.
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum_in,
    input  logic [WIDTH-1:0] n2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             neg,
    output logic             ovf
);

    // Counter must reach WIDTH, which is the index of the last bit edge.
    localparam int             c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH:0]     r_a;        // minuend, shifted right one bit per edge
    logic [WIDTH:0]     r_b;        // zero-extended subtrahend, shifted likewise
    logic [WIDTH:0]     r_res;      // difference bits enter from the MSB side
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_borrow;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_diff;
    logic               r_neg;
    logic               r_ovf;

    logic               w_a0;
    logic               w_b0;
    logic               w_d;
    logic               w_borrow_nxt;
    logic [WIDTH:0]     w_res_nxt;

    // Full-subtractor cell acting on the current LSBs of the operands.
    always_comb begin
        w_a0         = r_a[0];
        w_b0         = r_b[0];
        w_d          = w_a0 ^ w_b0 ^ r_borrow;
        w_borrow_nxt = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
        w_res_nxt    = {w_d, r_res[WIDTH:1]};
    end

    // Control FSM and datapath: accept, shift WIDTH+1 bits, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_a      <= sum_in;
                        r_b      <= {1'b0, n2};
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        r_state  <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    r_res    <= w_res_nxt;
                    r_a      <= {1'b0, r_a[WIDTH:1]};
                    r_b      <= {1'b0, r_b[WIDTH:1]};
                    r_borrow <= w_borrow_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    // Last bit edge: publish the result including this bit.
                    if (r_cnt == c_cnt_last) begin
                        r_state     <= c_st_done;
                        r_out_valid <= 1'b1;
                        r_diff      <= w_res_nxt[WIDTH-1:0];
                        r_neg       <= w_borrow_nxt;
                        r_ovf       <= w_res_nxt[WIDTH] & ~w_borrow_nxt;
                    end
                end
                c_st_done: begin
                    // Result fields stay as-is after the handshake.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = r_out_valid;
    assign diff_out  = r_diff;
    assign neg       = r_neg;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor. An arithmetic model
//             predicts handshake timing and results; directed vectors carry
//             hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   sum_in;
    logic [WIDTH-1:0] n2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff_out;
    logic             neg;
    logic             ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .n2        (n2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_out  (diff_out),
        .neg       (neg),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: busy for WIDTH+1 edges after an accepted operand pair, then
    // the arithmetic difference is offered until out_ready takes it.
    // ------------------------------------------------------------------
    bit               m_live = 0;
    int               m_busy = 0;
    bit               m_ov   = 0;
    logic [WIDTH-1:0] m_diff = '0;
    bit               m_neg  = 0;
    bit               m_ovf  = 0;
    logic [WIDTH-1:0] p_diff;
    bit               p_neg;
    bit               p_ovf;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1;
            m_busy = 0;
            m_ov   = 0;
            m_diff = '0;
            m_neg  = 0;
            m_ovf  = 0;
        end else if (m_ov) begin
            if (out_ready) m_ov = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_ov   = 1;
                m_diff = p_diff;
                m_neg  = p_neg;
                m_ovf  = p_ovf;
            end
        end else if (in_valid) begin
            int s;
            int b;
            int d;
            s      = int'(sum_in);
            b      = int'(n2);
            d      = s - b;
            p_diff = d[WIDTH-1:0];
            p_neg  = (d < 0);
            p_ovf  = (d > (1 << WIDTH) - 1);
            m_busy = WIDTH + 1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready",  32'(in_ready),  32'(!m_ov && (m_busy == 0)));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("diff_out",  32'(diff_out),  32'(m_diff));
            check("neg",       32'(neg),       32'(m_neg));
            check("ovf",       32'(ovf),       32'(m_ovf));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [WIDTH:0] s, input logic [WIDTH-1:0] b, output int acc);
        int g = 0;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        check("accept_timeout", 32'(in_ready), 32'd1);
        sum_in   = s;
        n2       = b;
        in_valid = 1'b1;
        tick();
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int done);
        int g = 0;
        while (!out_valid && g < 100) begin
            tick();
            g++;
        end
        check("result_timeout", 32'(out_valid), 32'd1);
        done = cyc;
    endtask

    task automatic run_op(input string name, input logic [WIDTH:0] s, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] ed, input bit en, input bit eo, output int acc);
        int done;
        start_op(s, b, acc);
        wait_result(done);
        check({name, "_latency"}, 32'(done - acc), 32'd17);
        check({name, "_diff"},    32'(diff_out),   32'(ed));
        check({name, "_neg"},     32'(neg),        32'(en));
        check({name, "_ovf"},     32'(ovf),        32'(eo));
    endtask

    initial begin
        int acc;
        int acc2;
        int done;
        logic [WIDTH-1:0] held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum_in    = '0;
        n2        = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff",      32'(diff_out),  32'd0);

        // Basic recovery, then in_ready one cycle after the handshake
        run_op("basic", 17'd17, 16'd9, 16'd8, 0, 0, acc);
        tick();
        check("basic_in_ready_after", 32'(in_ready),  32'd1);
        check("basic_out_valid_after", 32'(out_valid), 32'd0);

        // Adder round trip: sum = a + b, recover a
        run_op("rt0", 17'(11 + 13), 16'd13, 16'd11, 0, 0, acc);
        tick();
        run_op("rt1", 17'(27 + 35), 16'd35, 16'd27, 0, 0, acc);
        tick();
        run_op("rt2", 17'(83 + 89), 16'd89, 16'd83, 0, 0, acc);
        tick();

        // Borrow and overflow corners
        run_op("borrow", 17'd5, 16'd9, 16'hFFFC, 1, 0, acc);
        tick();
        run_op("ovf", 17'h1FFFF, 16'd0, 16'hFFFF, 0, 1, acc);
        tick();
        run_op("edge", 17'h10000, 16'd1, 16'hFFFF, 0, 0, acc);
        tick();

        // Backpressure: result held for 6 cycles with out_ready low
        out_ready = 1'b0;
        run_op("bp", 17'd300, 16'd45, 16'd255, 0, 0, acc);
        held = diff_out;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_diff_held", 32'(diff_out),  32'(held));
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_released", 32'(out_valid), 32'd0);

        // Busy: new operands during SHIFT must be ignored
        start_op(17'd1000, 16'd1, acc);
        for (int i = 0; i < 8; i++) begin
            in_valid = i[0];
            sum_in   = 17'(5000 + i);
            n2       = 16'd7;
            tick();
        end
        in_valid = 1'b0;
        wait_result(done);
        check("busy_latency", 32'(done - acc), 32'd17);
        check("busy_diff",    32'(diff_out),   32'd999);
        tick();

        // Reset at bit edge 8 aborts the operation
        start_op(17'd500, 16'd20, acc);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready",  32'(in_ready),  32'd1);
        check("rst_mid_diff",      32'(diff_out),  32'd0);
        check("rst_mid_neg",       32'(neg),       32'd0);
        check("rst_mid_ovf",       32'(ovf),       32'd0);
        repeat (20) tick();
        check("rst_mid_no_result", 32'(out_valid), 32'd0);
        run_op("post_rst", 17'd24, 16'd13, 16'd11, 0, 0, acc);
        tick();

        // Back-to-back with out_ready tied high
        run_op("b2b0", 17'd40000, 16'd1234, 16'd38766, 0, 0, acc);
        run_op("b2b1", 17'd2, 16'd3, 16'hFFFF, 1, 0, acc2);
        check("b2b_spacing", 32'(acc2 - acc), 32'(WIDTH + 3));
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
